// File: rtl/core.sv
// rtl/core.sv - shared core types for branch predictor feedback
package core;
    localparam int PC_W = 32;

    typedef struct packed {
        logic            valid;
        logic [PC_W-1:0] base_pc;
        logic            branch_taken;
    } branch_pred_fb_t;

    typedef struct packed {
        logic [PC_W-1:0] base_pc;
        logic            branch_taken;
    } branch_fb_entry_t;
endpackage

// File: rtl/branch_fb_arbiter_rr_arbiter.sv
// rtl/branch_fb_arbiter_rr_arbiter.sv - round-robin one-hot grant starting at ptr
module rr_arbiter #(
    parameter int n = 3
) (
    input  logic [n-1:0]         req,
    input  logic [$clog2(n)-1:0] ptr,
    input  logic                 allow,
    output logic [n-1:0]         gnt
);
    logic found;

    // Priority order is ptr, ptr+1, ... wrapping; the first requester in that order wins.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < n; i++) begin
                if (allow && !found && req[i] && (i == (int'(ptr) + k) % n)) begin
                    gnt[i] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/branch_fb_arbiter.sv
// rtl/branch_fb_arbiter.sv - serialises branch feedback from several paths into one port
// Optional pop/drop statistics counters enabled by BRANCH_FB_STATS_EN.
module branch_fb_arbiter
    import core::*;
#(
    parameter int fb_ports    = 3,
    parameter int queue_depth = 4,
    parameter int pc_width    = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               en,
    input  logic                               flush,
    input  logic [fb_ports-1:0]                fb_valid,
    input  logic [fb_ports-1:0][pc_width-1:0]  fb_base_pc,
    input  logic [fb_ports-1:0]                fb_taken,
    output logic [fb_ports-1:0]                fb_ready,
    output branch_pred_fb_t                    pred_fb
`ifdef BRANCH_FB_STATS_EN
    ,
    output logic [31:0]                        stat_fb_cnt,
    output logic [31:0]                        stat_drop_cnt
`endif
);
    localparam int PW = $clog2(queue_depth);
    localparam int RW = $clog2(fb_ports);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [PW:0]   cnt_t;

    localparam cnt_t FULL = cnt_t'(queue_depth);

    ptr_t             rd_ptr;
    ptr_t             wr_ptr;
    cnt_t             count;
    logic [RW-1:0]    rr_ptr;
    logic [RW-1:0]    rr_next;
    branch_fb_entry_t mem [queue_depth];
    branch_fb_entry_t acc_entry;
    logic             allow;
    logic             accept;
    logic             pop;

    // Full test uses the pre-pop count so ready never depends on the consumer.
    assign allow  = en && !flush && !rst && (count != FULL);
    assign pop    = en && !flush && !rst && (count != '0);
    assign accept = |(fb_ready & fb_valid);

    rr_arbiter #(.n(fb_ports)) u_rr (
        .req   (fb_valid),
        .ptr   (rr_ptr),
        .allow (allow),
        .gnt   (fb_ready)
    );

    always_comb begin
        acc_entry = '0;
        rr_next   = rr_ptr;
        for (int i = 0; i < fb_ports; i++) begin
            if (fb_ready[i]) begin
                acc_entry.base_pc      = fb_base_pc[i];
                acc_entry.branch_taken = fb_taken[i];
                rr_next                = RW'((i + 1) % fb_ports);
            end
        end
    end

    assign pred_fb.valid        = pop;
    assign pred_fb.base_pc      = pop ? mem[rd_ptr].base_pc : '0;
    assign pred_fb.branch_taken = pop ? mem[rd_ptr].branch_taken : 1'b0;

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= acc_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            rr_ptr <= '0;
        end else if (flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
                rr_ptr <= rr_next;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef BRANCH_FB_STATS_EN
    logic [32:0] drop_sum;

    assign drop_sum = {1'b0, stat_drop_cnt} + 33'(count);

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_fb_cnt   <= '0;
            stat_drop_cnt <= '0;
        end else begin
            if (pop && (stat_fb_cnt != '1)) begin
                stat_fb_cnt <= stat_fb_cnt + 1'b1;
            end
            if (flush) begin
                stat_drop_cnt <= drop_sum[32] ? '1 : drop_sum[31:0];
            end
        end
    end
`endif
endmodule

// File: tb/tb_branch_fb_arbiter.sv
// tb/tb_branch_fb_arbiter.sv - scoreboard bench for branch_fb_arbiter
module tb_branch_fb_arbiter;
    import core::*;

    localparam int N   = 3;
    localparam int D   = 4;
    localparam int PCW = 32;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     en;
    logic                     flush;
    logic [N-1:0]             fb_valid;
    logic [N-1:0][PCW-1:0]    fb_base_pc;
    logic [N-1:0]             fb_taken;
    logic [N-1:0]             fb_ready;
    branch_pred_fb_t          pred_fb;
`ifdef BRANCH_FB_STATS_EN
    logic [31:0]              stat_fb_cnt;
    logic [31:0]              stat_drop_cnt;
`endif

    always #5 clk = ~clk;

    branch_fb_arbiter #(.fb_ports(N), .queue_depth(D), .pc_width(PCW)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .flush      (flush),
        .fb_valid   (fb_valid),
        .fb_base_pc (fb_base_pc),
        .fb_taken   (fb_taken),
        .fb_ready   (fb_ready),
        .pred_fb    (pred_fb)
`ifdef BRANCH_FB_STATS_EN
        ,
        .stat_fb_cnt   (stat_fb_cnt),
        .stat_drop_cnt (stat_drop_cnt)
`endif
    );

    int               checks = 0;
    int               passed = 0;
    branch_fb_entry_t exp_q[$];
    int               m_rr = 0;
    longint           m_pops = 0;
    longint           m_drops = 0;
    bit               seen_reset = 0;
    logic [N-1:0]     acc_mask = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference: a queue of accepted feedback plus a fairness pointer, advanced once per clock.
    always @(negedge clk) begin : monitor
        logic [N-1:0] exp_rdy;
        logic         exp_v;
        int           g;
        int           idx;
        exp_rdy = '0;
        g = -1;
        if (en && !flush && !rst && exp_q.size() < D) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_rr + k) % N;
                if (g < 0 && fb_valid[idx]) g = idx;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        exp_v = en && !flush && !rst && (exp_q.size() != 0);

        check("fb_ready", 64'(fb_ready), 64'(exp_rdy));
        check("pred_valid", 64'(pred_fb.valid), 64'(exp_v));
        if (exp_v && pred_fb.valid) begin
            check("pred_pc", 64'(pred_fb.base_pc), 64'(exp_q[0].base_pc));
            check("pred_taken", 64'(pred_fb.branch_taken), 64'(exp_q[0].branch_taken));
        end
`ifdef BRANCH_FB_STATS_EN
        if (seen_reset) begin
            check("stat_fb_cnt", 64'(stat_fb_cnt), 64'(m_pops));
            check("stat_drop_cnt", 64'(stat_drop_cnt), 64'(m_drops));
        end
`endif
        acc_mask = exp_rdy & fb_valid;

        if (rst) begin
            exp_q.delete();
            m_rr = 0;
            m_pops = 0;
            m_drops = 0;
            seen_reset = 1;
        end else if (flush) begin
            m_drops += exp_q.size();
            exp_q.delete();
        end else begin
            if (exp_v) begin
                void'(exp_q.pop_front());
                m_pops++;
            end
            if (g >= 0) begin
                exp_q.push_back('{base_pc: fb_base_pc[g], branch_taken: fb_taken[g]});
                m_rr = (g + 1) % N;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_accepted();
        fb_valid = fb_valid & ~acc_mask;
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0;
        flush = 1'b0;
        fb_valid = '0;
        fb_taken = '0;
        fb_base_pc = '0;
        step();
        step();

        // Three simultaneous requesters served in order 0, 1, 2
        rst = 1'b0;
        en = 1'b1;
        fb_base_pc[0] = 32'h100;
        fb_base_pc[1] = 32'h104;
        fb_base_pc[2] = 32'h108;
        fb_taken = 3'b101;
        fb_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
            step();
            drop_accepted();
        end

        // Wrap-around: after port 1 wins, port 0 beats port 1
        fb_base_pc[1] = 32'h200;
        fb_valid = 3'b010;
        step();
        drop_accepted();
        fb_base_pc[0] = 32'h300;
        fb_base_pc[1] = 32'h304;
        fb_valid = 3'b011;
        for (int c = 0; c < 5; c++) begin
            step();
            drop_accepted();
        end

        // Steady single-port stream, one new entry per accept
        for (int c = 0; c < 20; c++) begin
            fb_valid = 3'b001;
            fb_base_pc[0] = 32'h1000 + 32'(c * 4);
            fb_taken[0] = c[0];
            step();
        end
        fb_valid = '0;
        step();

        // Flush and reset while feedback is in flight
        fb_valid = 3'b001;
        fb_base_pc[0] = 32'h400;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        fb_valid = 3'b011;
        fb_base_pc[1] = 32'h500;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        step();
        fb_valid = '0;

        // Randomized traffic with enable gaps, flushes and occasional resets
        for (int c = 0; c < 3000; c++) begin
            drop_accepted();
            for (int i = 0; i < N; i++) begin
                if (!fb_valid[i] && $urandom_range(0, 1) == 1) begin
                    fb_valid[i] = 1'b1;
                    fb_base_pc[i] = $urandom;
                    fb_taken[i] = 1'($urandom_range(0, 1));
                end else if (fb_valid[i] && $urandom_range(0, 15) == 0) begin
                    fb_valid[i] = 1'b0;
                end
            end
            if ($urandom_range(0, 7) == 0) en = ~en;
            flush = ($urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;
        flush = 1'b0;
        fb_valid = '0;
        step();
        step();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
